// File: rtl/snes_poll_sequencer_if.sv
// Bus between the SNES pad poll sequencer and its consumer: pad pins plus decoded button results.
// valid is a one-cycle strobe with no ready: buttons*/pressed*/present are coherent while valid=1 and hold afterwards.
interface snes_poll_sequencer_if;
    logic        start;
    logic [1:0]  pad_data;
    logic        pad_latch;
    logic        pad_clk;
    logic        busy;
    logic [11:0] buttons0;
    logic [11:0] buttons1;
    logic [11:0] pressed0;
    logic [11:0] pressed1;
    logic [1:0]  present;
    logic        valid;

    modport master (
        input  start, pad_data,
        output pad_latch, pad_clk, busy, buttons0, buttons1,
               pressed0, pressed1, present, valid
    );

    modport slave (
        output start, pad_data,
        input  pad_latch, pad_clk, busy, buttons0, buttons1,
               pressed0, pressed1, present, valid
    );
endinterface

// File: rtl/snes_poll_sequencer.sv
// Polls two SNES pads in parallel: latch pulse, 16 shift clocks, then publishes the
// decoded button state, newly-pressed edges and presence flags.
module snes_poll_sequencer #(
    parameter int LATCH_CYC = 300,
    parameter int HALF_CYC  = 150
) (
    input  logic                  clk,
    input  logic                  rst_n,
    snes_poll_sequencer_if.master bus,
    output logic [2:0]            dbg_state
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        DONE     = 3'd4
    } state_t;

    // Counter only has to reach the longest phase length minus one.
    localparam int PHASE_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int CNT_W     = $clog2(PHASE_MAX);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] phase_cnt;
    logic [3:0]       bit_cnt;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [15:0]      sr0;
    logic [15:0]      sr1;
    logic             sample;
    logic             latch_o;
    logic             clk_o;
    logic             busy_o;

    logic [11:0] buttons0_q;
    logic [11:0] buttons1_q;
    logic [11:0] pressed0_q;
    logic [11:0] pressed1_q;
    logic [1:0]  present_q;
    logic        valid_q;

    // After 16 shifts sr[15] holds serial bit 1 (B) and sr[3:0] hold the ID bits.
    logic [1:0]  present_new;
    logic [11:0] buttons0_new;
    logic [11:0] buttons1_new;

    assign present_new[0] = &sr0[3:0];
    assign present_new[1] = &sr1[3:0];
    assign buttons0_new   = present_new[0] ? ~sr0[15:4] : 12'h000;
    assign buttons1_new   = present_new[1] ? ~sr1[15:4] : 12'h000;

    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        latch_o   = 1'b0;
        clk_o     = 1'b1;
        busy_o    = 1'b1;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (bus.start) state_nxt = LATCH;
            end
            LATCH: begin
                latch_o = 1'b1;
                if (phase_cnt == LATCH_LAST) state_nxt = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (phase_cnt == HALF_LAST) begin
                    sample    = 1'b1;
                    state_nxt = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                clk_o = 1'b0;
                if (phase_cnt == HALF_LAST) state_nxt = (bit_cnt == 4'd15) ? DONE : SHIFT_HI;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase_cnt <= '0;
            bit_cnt   <= 4'd0;
            sync1     <= 2'b00;
            sync2     <= 2'b00;
            sr0       <= 16'h0000;
            sr1       <= 16'h0000;
        end else begin
            state <= state_nxt;
            sync1 <= bus.pad_data;
            sync2 <= sync1;
            // Every phase boundary is a state change, so the counter restarts per phase.
            if (state_nxt != state || state == IDLE) phase_cnt <= '0;
            else                                     phase_cnt <= phase_cnt + 1'b1;
            if (state == LATCH)                                 bit_cnt <= 4'd0;
            else if (state == SHIFT_LO && state_nxt != SHIFT_LO) bit_cnt <= bit_cnt + 4'd1;
            if (sample) begin
                sr0 <= {sr0[14:0], sync2[0]};
                sr1 <= {sr1[14:0], sync2[1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buttons0_q <= 12'h000;
            buttons1_q <= 12'h000;
            pressed0_q <= 12'h000;
            pressed1_q <= 12'h000;
            present_q  <= 2'b00;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (state == DONE) begin
                buttons0_q <= buttons0_new;
                buttons1_q <= buttons1_new;
                pressed0_q <= buttons0_new & ~buttons0_q;
                pressed1_q <= buttons1_new & ~buttons1_q;
                present_q  <= present_new;
                valid_q    <= 1'b1;
            end
        end
    end

    assign bus.pad_latch = latch_o;
    assign bus.pad_clk   = clk_o;
    assign bus.busy      = busy_o;
    assign bus.buttons0  = buttons0_q;
    assign bus.buttons1  = buttons1_q;
    assign bus.pressed0  = pressed0_q;
    assign bus.pressed1  = pressed1_q;
    assign bus.present   = present_q;
    assign bus.valid     = valid_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_snes_poll_sequencer.sv
// Bench for snes_poll_sequencer: behavioural pad model, pin-timing checks against
// closed-form cycle arithmetic, and a result scoreboard fed from a table and a reference model.
module tb_snes_poll_sequencer;
  localparam int L        = 4;
  localparam int H        = 3;
  localparam int VALID_AT = L + 32 * H + 2;
  localparam int W        = 50;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  snes_poll_sequencer_if bus();

  snes_poll_sequencer #(.LATCH_CYC(L), .HALF_CYC(H)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_exp;

  // Serial levels per pad: bit 15 is shifted out first.
  logic [15:0] lv0 = 16'hFFFF;
  logic [15:0] lv1 = 16'hFFFF;
  int          pad_idx  = 15;
  logic        prev_pclk = 1'b1;
  logic [11:0] m_prev0 = 12'h000;
  logic [11:0] m_prev1 = 12'h000;

  typedef struct {
    logic [15:0] l0;
    logic [15:0] l1;
    bit          pulse_busy;
    logic [11:0] b0;
    logic [11:0] b1;
    logic [11:0] p0;
    logic [11:0] p1;
    logic [1:0]  pres;
  } vec_t;

  vec_t vecs[6];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- pad model ----------------
  always @(negedge clk) begin
    if (bus.pad_latch === 1'b1) pad_idx = 0;
    else if (bus.pad_clk === 1'b1 && prev_pclk == 1'b0 && pad_idx < 15) pad_idx = pad_idx + 1;
    prev_pclk = bus.pad_clk;
    bus.pad_data = {lv1[15-pad_idx], lv0[15-pad_idx]};
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp_v);
    end
  endtask

  function automatic logic [W-1:0] outs();
    return {bus.buttons0, bus.buttons1, bus.pressed0, bus.pressed1, bus.present};
  endfunction

  // Scoreboard: every valid strobe consumes one expected result.
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_valid actual=valid required=no_valid");
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_outputs", outs(), sb_exp);
      end
    end
  end

  // Reference model: decode straight from the serial levels and remember last buttons.
  function automatic logic [W-1:0] model_poll(input logic [15:0] l0, input logic [15:0] l1);
    logic [1:0]  pres;
    logic [11:0] b0;
    logic [11:0] b1;
    logic [W-1:0] r;
    pres[0] = (l0[3:0] == 4'hF);
    pres[1] = (l1[3:0] == 4'hF);
    b0 = pres[0] ? ~l0[15:4] : 12'h000;
    b1 = pres[1] ? ~l1[15:4] : 12'h000;
    r = {b0, b1, b0 & ~m_prev0, b1 & ~m_prev1, pres};
    m_prev0 = b0;
    m_prev1 = b1;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_poll(input logic [15:0] l0, input logic [15:0] l1, input bit pulse_busy);
    int errs;
    int first_bad;
    int s;
    logic [3:0] exp_pins;
    logic [3:0] act_pins;
    errs = 0;
    first_bad = -1;
    lv0 = l0;
    lv1 = l1;
    @(posedge clk);
    #1 bus.start = 1'b1;
    for (int c = 0; c <= VALID_AT + 8; c++) begin
      @(negedge clk);
      s = c - (L + 1);
      exp_pins[3] = (c >= 1 && c <= L);
      exp_pins[2] = !(s >= 0 && s < 32 * H && ((s / H) % 2 == 1));
      exp_pins[1] = (c >= 1 && c <= L + 32 * H + 1);
      exp_pins[0] = (c == VALID_AT);
      act_pins = {bus.pad_latch, bus.pad_clk, bus.busy, bus.valid};
      if (act_pins !== exp_pins) begin
        errs++;
        if (first_bad < 0) first_bad = c;
      end
      @(posedge clk);
      #1 bus.start = pulse_busy && (c + 1 == 10 || c + 1 == 50);
    end
    check($sformatf("pins_bad_cycles(first=%0d)", first_bad), 64'(errs), 64'd0);
  endtask

  task automatic held_start_seq();
    bit done;
    lv0 = 16'h0F0F;
    lv1 = 16'hFFFF;
    exp_q.push_back(model_poll(lv0, lv1));
    exp_q.push_back(model_poll(lv0, lv1));
    @(posedge clk);
    #1 bus.start = 1'b1;
    repeat (VALID_AT) @(posedge clk);
    @(negedge clk);
    check("held_idle_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("held_restart_latch_busy", 64'({bus.pad_latch, bus.busy}), 64'd3);
    bus.start = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) done = 1'b1;
    end
    check("held_second_done", 64'(done), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_mid_poll_seq();
    lv0 = 16'h3C3F;
    lv1 = 16'hA5AF;
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (39) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_pins", 64'({bus.pad_latch, bus.pad_clk, bus.busy, bus.valid}), 64'b0100);
    check("rst_mid_outputs", 64'(outs()), 64'd0);
    m_prev0 = 12'h000;
    m_prev1 = 12'h000;
    repeat (130) @(negedge clk);
  endtask

  // ---------------- main ----------------
  initial begin
    vecs[0] = '{16'hA5AF, 16'h0000, 1'b0, 12'h5A5, 12'h000, 12'h5A5, 12'h000, 2'b01};
    vecs[1] = '{16'h7FFF, 16'h0000, 1'b1, 12'h800, 12'h000, 12'h800, 12'h000, 2'b01};
    vecs[2] = '{16'h7F7F, 16'h0000, 1'b0, 12'h808, 12'h000, 12'h008, 12'h000, 2'b01};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 12'h000, 12'h000, 12'h000, 12'h000, 2'b11};
    vecs[4] = '{16'hFFF0, 16'hEDCF, 1'b1, 12'h000, 12'h123, 12'h000, 12'h123, 2'b10};
    vecs[5] = '{16'h000E, 16'h000F, 1'b0, 12'h000, 12'hFFF, 12'h000, 12'hEDC, 2'b10};

    bus.start = 1'b0;
    bus.pad_data = 2'b11;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_pins", 64'({bus.pad_latch, bus.pad_clk, bus.busy, bus.valid}), 64'b0100);
    check("reset_outputs", 64'(outs()), 64'd0);

    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({vecs[i].b0, vecs[i].b1, vecs[i].p0, vecs[i].p1, vecs[i].pres});
      run_poll(vecs[i].l0, vecs[i].l1, vecs[i].pulse_busy);
      m_prev0 = vecs[i].b0;
      m_prev1 = vecs[i].b1;
    end

    held_start_seq();
    reset_mid_poll_seq();

    for (int i = 0; i < 8; i++) begin
      logic [15:0] r0;
      logic [15:0] r1;
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      if ($urandom_range(0, 3) != 0) r0[3:0] = 4'hF;
      if ($urandom_range(0, 3) != 0) r1[3:0] = 4'hF;
      exp_q.push_back(model_poll(r0, r1));
      run_poll(r0, r1, $urandom_range(0, 1) == 1);
    end

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
